parity_rx: RTL and testbench

//   Serial frame receiver with XOR parity checking: the receive end of the

---
 rtl/parity_rx.sv | 142 ++++++++++++++
 tb/tb_parity_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parity_rx.sv
// parity_rx: oversampling serial frame receiver with XOR parity checking.
// Frame: start(0), DATA_W data bits LSB first, parity, stop(1).
// Each received word is presented with parity and framing error flags.
module parity_rx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxd,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] MID_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic          ODD = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BRK    = 3'd5
   } state_t;

   state_t            r_state, w_next;
   logic [1:0]        r_sync;
   logic [CW-1:0]     r_cnt;
   logic [BW-1:0]     r_bitn;
   logic [DATA_W-1:0] r_sr, w_sr_next;
   logic              r_acc, r_perr;
   logic [DATA_W-1:0] r_data;
   logic              r_valid, r_parity_err, r_frame_err;
   logic              w_rxs, w_mid, w_end;

   assign w_rxs = r_sync[1];
   assign w_mid = (r_cnt == MID_CNT);
   assign w_end = (r_cnt == END_CNT);

   // Two-flop synchroniser for the asynchronous line; idles high
   always_ff @(posedge clk) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], rxd};
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; after the start mid-point, w_end marks each later bit centre
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (!w_rxs) w_next = S_START;
         S_START:  if (w_mid) w_next = w_rxs ? S_IDLE : S_DATA;
         S_DATA:   if (w_end && r_bitn == LAST_BIT) w_next = S_PARITY;
         S_PARITY: if (w_end) w_next = S_STOP;
         S_STOP:   if (w_end) w_next = w_rxs ? S_IDLE : S_BRK;
         S_BRK:    if (w_rxs) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Output/helper logic: busy flag and right-shift of the data register (new bit at MSB)
   always_comb begin
      busy                 = (r_state != S_IDLE);
      w_sr_next            = r_sr >> 1;
      w_sr_next[DATA_W-1]  = w_rxs;
   end

   // Datapath: bit timing, data capture, parity accumulation and word presentation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_bitn       <= '0;
         r_sr         <= '0;
         r_acc        <= 1'b0;
         r_perr       <= 1'b0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt  <= '0;
               r_bitn <= '0;
               r_acc  <= 1'b0;
            end
            S_START: r_cnt <= w_mid ? '0 : r_cnt + 1'b1;
            S_DATA: begin
               if (w_end) begin
                  r_cnt  <= '0;
                  r_sr   <= w_sr_next;
                  r_acc  <= r_acc ^ w_rxs;
                  r_bitn <= r_bitn + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (w_end) begin
                  r_cnt  <= '0;
                  r_perr <= r_acc ^ w_rxs ^ ODD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_end) begin
                  r_cnt        <= '0;
                  r_data       <= r_sr;
                  r_parity_err <= r_perr;
                  r_frame_err  <= ~w_rxs;
                  r_valid      <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign data       = r_data;
   assign valid      = r_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: drives serial frames into an even- and an odd-parity receiver
// sharing one line, and compares every presented word with a frame-level model.
module tb_parity_rx;
   localparam int DW = 8;
   localparam int C  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rxd = 1'b1;
   logic [DW-1:0] data_e, data_o;
   logic valid_e, perr_e, ferr_e, busy_e;
   logic valid_o, perr_o, ferr_o, busy_o;

   parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_ODD(0)) dut_e (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data_e), .valid(valid_e),
      .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e));
   parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_ODD(1)) dut_o (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data_o), .valid(valid_o),
      .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // expected word: {data, perr_even, perr_odd, frame_err}
   logic [DW+2:0] xq[$];
   // received words: {data, parity_err, frame_err}
   logic [DW+1:0] rq_e[$], rq_o[$];
   int dbl = 0;
   logic pv_e = 1'b0, pv_o = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: capture every valid pulse, and flag back-to-back valid cycles
   always @(negedge clk) begin
      if (valid_e) rq_e.push_back({data_e, perr_e, ferr_e});
      if (valid_o) rq_o.push_back({data_o, perr_o, ferr_o});
      if ((valid_e && pv_e) || (valid_o && pv_o)) dbl++;
      pv_e = valid_e;
      pv_o = valid_o;
   end

   task automatic idle(input int cyc);
      for (int i = 0; i < cyc; i++) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      rxd = b;
      idle(C - 1);
   endtask

   // Send one frame and record what the receivers should report for it
   task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stp);
      logic pe;
      pe = (^d) ^ p;
      xq.push_back({d, pe, ~pe, ~stp});
      drive_bit(1'b0);
      for (int i = 0; i < DW; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(stp);
   endtask

   // Compare received words with the expected list, then clear both
   task automatic drain(input string tag);
      logic [DW+2:0] x;
      logic [DW+1:0] re, ro;
      chk({tag, "_cnt_e"}, rq_e.size(), xq.size());
      chk({tag, "_cnt_o"}, rq_o.size(), xq.size());
      while (xq.size() > 0 && rq_e.size() > 0 && rq_o.size() > 0) begin
         x  = xq.pop_front();
         re = rq_e.pop_front();
         ro = rq_o.pop_front();
         chk({tag, "_data"}, re[DW+1:2], x[DW+2:3]);
         chk({tag, "_perr_e"}, re[1], x[2]);
         chk({tag, "_ferr_e"}, re[0], x[0]);
         chk({tag, "_data_o"}, ro[DW+1:2], x[DW+2:3]);
         chk({tag, "_perr_o"}, ro[1], x[1]);
         chk({tag, "_ferr_o"}, ro[0], x[0]);
      end
      xq.delete();
      rq_e.delete();
      rq_o.delete();
   endtask

   initial begin
      int bc;
      logic [DW-1:0] d;
      logic p, s;

      rst_n = 1'b0;
      idle(3);
      chk("rst_out_e", {data_e, valid_e, perr_e, ferr_e, busy_e}, 0);
      chk("rst_out_o", {data_o, valid_o, perr_o, ferr_o, busy_o}, 0);
      rst_n = 1'b1;
      idle(2 * C);

      // good frame, even parity bit
      send_frame(8'hA5, 1'b0, 1'b1);
      drain("a5_p0");
      idle(C);
      chk("a5_busy_idle", {busy_e, busy_o}, 0);

      // same data with the opposite parity bit
      send_frame(8'hA5, 1'b1, 1'b1);
      drain("a5_p1");
      idle(C);

      // framing error followed by a long break
      send_frame(8'h0F, 1'b0, 1'b0);
      rxd = 1'b0;
      idle(40 * C);
      chk("brk_busy", {busy_e, busy_o}, 2'b11);
      drain("brk");
      rxd = 1'b1;
      idle(2 * C);
      chk("brk_exit_busy", {busy_e, busy_o}, 0);
      send_frame(8'h01, 1'b1, 1'b1);
      drain("after_brk");
      idle(C);

      // short glitch is rejected
      bc = 0;
      @(negedge clk);
      rxd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy_e) bc++;
      end
      rxd = 1'b1;
      for (int i = 0; i < 3 * C; i++) begin
         @(negedge clk);
         if (busy_e) bc++;
      end
      chk("glitch_busy_seen", bc > 0, 1);
      chk("glitch_busy_le8", bc <= 8, 1);
      chk("glitch_busy_end", busy_e, 0);
      drain("glitch");

      // reset in the middle of data bit 4 of 0xFF
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      idle(C / 2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_e", {data_e, valid_e, perr_e, ferr_e, busy_e}, 0);
      chk("midrst_out_o", {data_o, valid_o, perr_o, ferr_o, busy_o}, 0);
      rst_n = 1'b1;
      idle(2 * C);
      drain("midrst");
      send_frame(8'h3C, 1'b0, 1'b1);
      drain("post_rst");
      idle(C);

      // back-to-back frames with no idle gap
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      drain("b2b");
      idle(C);

      // random frames: random data, parity bit, stop bit, gaps
      for (int n = 0; n < 40; n++) begin
         d = DW'($urandom);
         p = 1'($urandom);
         s = ($urandom_range(0, 4) != 0);
         send_frame(d, p, s);
         if (!s) begin
            @(negedge clk);
            rxd = 1'b1;
            idle(C);
         end else begin
            idle($urandom_range(0, 2) * C);
         end
         drain("rnd");
      end

      chk("valid_double", dbl, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
